// File: rtl/uart_pkg.sv
// Shared UART types: byte type, default end-of-message byte and holding-register state.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t EOM_CHAR_DEFAULT = 8'h0A;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: one-hot winner among req, searching upward from index ptr with wrap.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner
);

    logic          found;
    logic [PW:0]   pos;

    // ptr < N and k < N, so one conditional subtract is enough for the wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N)) begin
                pos = pos - (PW + 1)'(N);
            end
            if (!found && req[pos[PW-1:0]]) begin
                winner[pos[PW-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a UART transmitter through a one-entry holding register.
// Define UART_ARB_LOCK_EN to keep a requester granted until it sends EOM_CHAR.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter byte_t       EOM_CHAR = EOM_CHAR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    hold_state_t        state;
    logic [PW-1:0]      last_winner;
    logic [PW-1:0]      start_ptr;
    logic [PW-1:0]      win_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] winner;
    byte_t              win_byte;
    logic               can_accept;
    logic               accept;

    assign start_ptr = (last_winner == PW'(NUM_REQ - 1)) ? '0 : last_winner + 1'b1;

`ifdef UART_ARB_LOCK_EN
    logic               lock_on;
    logic [NUM_REQ-1:0] lock_mask;

    assign eligible = lock_on ? (req_valid & lock_mask) : req_valid;
`else
    assign eligible = req_valid;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req    (eligible),
        .ptr    (start_ptr),
        .winner (winner)
    );

    // Refill is allowed in the same cycle the held byte leaves, so no bubble.
    assign can_accept = !rst && ((state == ST_EMPTY) || tx_ready);
    assign req_ready  = can_accept ? winner : '0;
    assign accept     = |req_ready;
    assign tx_valid   = (state == ST_FULL);

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx  = PW'(i);
                win_byte = req_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            tx_data     <= '0;
            grant       <= '0;
            last_winner <= PW'(NUM_REQ - 1);
        end else if (accept) begin
            state       <= ST_FULL;
            tx_data     <= win_byte;
            grant       <= winner;
            last_winner <= win_idx;
        end else if ((state == ST_FULL) && tx_ready) begin
            state <= ST_EMPTY;
            grant <= '0;
        end
    end

`ifdef UART_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_on   <= 1'b0;
            lock_mask <= '0;
        end else if (accept) begin
            lock_on   <= (win_byte != EOM_CHAR);
            lock_mask <= winner;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter against a queue-based reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 2;
    localparam logic [7:0]  EOM = 8'h0A;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [N-1:0]     grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (N),
        .EOM_CHAR (EOM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant)
    );

    typedef struct {
        logic [7:0]  data;
        int unsigned who;
    } item_t;

    int          checks   = 0;
    int          failures = 0;
    item_t       sb[$];
    logic [7:0]  log_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  src [N][$];
    bit          hold [N];
    logic [N-1:0] dut_rr;
    int unsigned vprob;
    int unsigned rprob;

    // Reference model: holding-register occupancy, last winner, optional lock owner.
    bit          m_full;
    int unsigned m_last;
`ifdef UART_ARB_LOCK_EN
    bit          m_lock;
    int unsigned m_lock_who;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_last = N - 1;
`ifdef UART_ARB_LOCK_EN
        m_lock     = 1'b0;
        m_lock_who = 0;
`endif
    endtask

    // Monitor: every presented byte must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: tx_valid with byte %02h but nothing expected", tx_data);
            end else begin
                check("tx_data", 32'(tx_data), 32'(sb[0].data));
                check("grant", 32'(grant), 32'(1) << sb[0].who);
                if (tx_ready) begin
                    log_q.push_back(tx_data);
                    sb.delete(0);
                end
            end
        end
    end

    task automatic model_step();
        logic [N-1:0] exp_rdy;
        int           win;
        int unsigned  idx;
        bit           ok;
        exp_rdy = '0;
        win     = -1;
        dut_rr  = req_ready;
        if (rst) begin
            check("ready_in_rst", 32'(req_ready), 32'(0));
            model_reset();
            sb.delete();
            dut_rr = '0;
            return;
        end
        check("tx_valid", 32'(tx_valid), 32'(m_full));
        if (!m_full || tx_ready) begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                ok  = req_valid[idx];
`ifdef UART_ARB_LOCK_EN
                if (m_lock && idx != m_lock_who) ok = 1'b0;
`endif
                if (win < 0 && ok) win = int'(idx);
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (win >= 0) begin
            sb.push_back('{data: req_data[win*8 +: 8], who: win});
            m_last = win;
            m_full = 1'b1;
`ifdef UART_ARB_LOCK_EN
            m_lock     = (req_data[win*8 +: 8] != EOM);
            m_lock_who = win;
`endif
        end else if (m_full && tx_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hold[i] && dut_rr[i]) begin
                src[i].delete(0);
                hold[i] = 1'b0;
            end
        end
        dut_rr = '0;
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && src[i].size() > 0 && $urandom_range(99) < vprob) hold[i] = 1'b1;
            req_valid[i]       = hold[i];
            req_data[i*8 +: 8] = hold[i] ? src[i][0] : 8'($urandom);
        end
        tx_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (src[i].size() != 0 || hold[i]) return 1'b0;
        return (sb.size() == 0) && !tx_valid;
    endfunction

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (!all_idle() && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: still busy after %0d cycles, pending %0d", n, sb.size());
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src[i].delete();
            hold[i] = 1'b0;
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check(name, 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '1;
        tx_ready  = 1'b0;
        dut_rr    = '0;
        vprob     = 100;
        rprob     = 100;
        model_reset();
        clear_src();
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        repeat (2) cycle();
        rst = 1'b0;

        // Single requester.
        clear_src();
        src[0].push_back(8'h41);
        vprob = 100; rprob = 100;
        drive();
        drain(50);
        exp_q.push_back(8'h41);
        check_log("single");

        // Contention with continuous tx_ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src[0].push_back(8'(8'h10 + i));
            src[1].push_back(8'(8'h20 + i));
        end
        src[0].push_back(EOM);
        src[1].push_back(EOM);
        drive();
        drain(100);
`ifdef UART_ARB_LOCK_EN
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(EOM);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h20 + i));
        exp_q.push_back(EOM);
`else
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        exp_q.push_back(EOM);
        exp_q.push_back(EOM);
`endif
        check_log("contention");

        // Backpressure: 8'h55 held for 10 cycles.
        do_reset();
        src[0].push_back(8'h55); src[0].push_back(EOM);
        src[1].push_back(8'h66); src[1].push_back(EOM);
        rprob = 0;
        drive();
        cycle();
        repeat (10) cycle();
        #3;
        check("bp_tx_data", 32'(tx_data), 32'h55);
        check("bp_tx_valid", 32'(tx_valid), 32'(1));
        check("bp_req_ready", 32'(req_ready), 32'(0));
        rprob = 100;
        drain(100);
        check("bp_count", 32'(log_q.size()), 32'(4));

        // Message lock.
        do_reset();
        src[0].push_back(8'h61); src[0].push_back(8'h62); src[0].push_back(EOM);
        src[1].push_back(8'h31); src[1].push_back(8'h32); src[1].push_back(8'h33); src[1].push_back(EOM);
        drive();
        drain(100);
`ifdef UART_ARB_LOCK_EN
        exp_q = '{8'h61, 8'h62, EOM, 8'h31, 8'h32, 8'h33, EOM};
`else
        exp_q = '{8'h61, 8'h31, 8'h62, 8'h32, EOM, 8'h33, EOM};
`endif
        check_log("lock");

        // Reset while FULL and stalled.
        do_reset();
        src[1].push_back(8'hAA); src[1].push_back(EOM);
        rprob = 0;
        drive();
        for (int n = 0; n < 20 && !tx_valid; n++) cycle();
        check("mid_full", 32'(tx_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'(0));
        check("mid_rst_grant", 32'(grant), 32'(0));
        check("mid_rst_tx_data", 32'(tx_data), 32'(0));
        check("mid_rst_req_ready", 32'(req_ready), 32'(0));
        cycle();
        rst = 1'b0;
        clear_src();
        src[0].push_back(8'hB0); src[0].push_back(EOM);
        src[1].push_back(8'hC1); src[1].push_back(EOM);
        rprob = 100;
        drive();
        drain(100);
        check("mid_first", 32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'hB0);
        check("mid_count", 32'(log_q.size()), 32'(4));

        // Full byte range through each requester with random handshakes.
        do_reset();
        for (int v = 0; v < 256; v++) begin
            src[0].push_back(8'(v));
            src[1].push_back(8'(255 - v));
        end
        src[0].push_back(EOM);
        src[1].push_back(EOM);
        vprob = 70; rprob = 60;
        drive();
        drain(6000);
        check("range_count", 32'(log_q.size()), 32'(514));

        // Random bursts.
        for (int b = 0; b < 3; b++) begin
            clear_src();
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < int'($urandom_range(5, 20)); k++) src[i].push_back(8'($urandom));
                src[i].push_back(EOM);
            end
            vprob = $urandom_range(30, 100);
            rprob = $urandom_range(30, 100);
            drive();
            drain(2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of byte requesters (2..8).
REQ-002 SHALL have parameter EOM_CHAR, default 8'h0A, end-of-message byte used by lock mode.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_data  in  NUM_REQ*8  byte from requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_valid  in  NUM_REQ  requester i offers a byte.
REQ-007 SHALL have port req_ready  out  NUM_REQ  byte from requester i accepted this cycle.
REQ-008 SHALL have port tx_data  out  8  byte to uart_transmitter data_in.
REQ-009 SHALL have port tx_valid  out  1  to uart_transmitter data_in_valid.
REQ-010 SHALL have port tx_ready  in  1  from uart_transmitter data_in_ready.
REQ-011 SHALL have port grant  out  NUM_REQ  one-hot owner of the byte in the holding register; 0 when empty.

Function
REQ-012 SHALL keep a one-entry holding register (tx_data, tx_valid, grant); state EMPTY (tx_valid=0) or FULL (tx_valid=1).
REQ-013 SHALL accept a byte when EMPTY, or when FULL and tx_valid&tx_ready in the same cycle (back-to-back, no bubble).
REQ-014 SHALL, on an accept cycle, assert exactly one req_ready bit: the round-robin winner among eligible req_valid bits; all other bits 0.
REQ-015 SHALL search round-robin starting at index (last_winner+1) mod NUM_REQ; last_winner updates only on an accept.
REQ-016 SHALL present the accepted byte on tx_data with tx_valid=1 on the next cycle (latency 1).
REQ-017 SHALL hold tx_data, tx_valid and grant stable while tx_valid=1 and tx_ready=0.
REQ-018 SHALL go FULL->EMPTY on tx_valid&tx_ready with no eligible request; FULL->FULL with new byte if one is accepted.
REQ-019 SHALL keep req_ready combinational from req_valid, state and tx_ready; it SHALL NOT depend on req_data.
REQ-020 SHALL never drop or duplicate a byte: each req_valid&req_ready pair yields exactly one tx_valid&tx_ready pair, in order.
REQ-021 SHALL, with no req_valid, leave the state and last_winner unchanged.

Reset
REQ-022 SHALL on rst force tx_valid=0, tx_data=8'h00, grant=0, last_winner=NUM_REQ-1 (requester 0 first), lock cleared.
REQ-023 SHALL discard a held byte if rst is asserted mid-operation; req_ready SHALL be 0 while rst is high.

Configuration
REQ-024 SHALL support macro UART_ARB_LOCK_EN.
REQ-025 SHALL, with UART_ARB_LOCK_EN defined, lock to requester i after accepting a non-EOM_CHAR byte from it: only i is eligible until it sends EOM_CHAR, then the lock clears and round-robin resumes.
REQ-026 SHALL, with UART_ARB_LOCK_EN undefined, arbitrate per byte with no lock state and no EOM_CHAR logic.

Structure
REQ-027 SHALL take EOM_CHAR default and the byte typedef from shared package uart_pkg.
REQ-028 SHALL place the winner selection in sub-module rr_pick (combinational; inputs request vector and pointer, output one-hot winner).

Verification
REQ-029 SHALL cover single requester: req0 sends 8'h41 with tx_ready=1 -> tx_data=8'h41, tx_valid=1 one cycle later, grant=2'b01.
REQ-030 SHALL cover contention: req0 and req1 both valid continuously, tx_ready=1 -> tx order req0,req1,req0,req1, no bubble cycles.
REQ-031 SHALL cover backpressure: tx_ready=0 for 10 cycles with byte 8'h55 held -> tx_data stays 8'h55, all req_ready=0, then drains on tx_ready=1.
REQ-032 SHALL cover lock (macro defined): req0 sends "ab\n", req1 valid throughout -> tx order a,b,\n then req1 bytes; without macro -> a,req1,b,req1,\n.
REQ-033 SHALL cover reset mid-transfer: rst during FULL with tx_ready=0 -> tx_valid=0 at once, next accept starts at req0.
REQ-034 SHALL cover the full byte range: all 256 values via each requester -> tx_data matches the input bit-for-bit.
